espic_n: RTL and testbench
==========================

ESPIC_N -- requirements
Module: espic_n

Interface
REQ-001 SHALL provide parameter N_NODES, default 2, number of CPU nodes (legal 1..15).
REQ-002 SHALL provide parameter TICK_PERIOD, default 1000000000, tick period in CLK cycles (>= 2).
REQ-003 SHALL provide parameter TICK_LEN, default 100, tick high time in cycles (1..TICK_PERIOD-1).
REQ-004 SHALL provide parameter PULSE_LEN, default 1000, mutex/command IRQ pulse length in cycles (>= 1).
REQ-005 SHALL provide port CLK  input  1  sole clock, all logic on rising edge.
REQ-006 SHALL provide port RST  input  1  asynchronous, active-low reset.
REQ-007 SHALL provide port ext_signal  input  1  asynchronous external event.
REQ-008 SHALL provide port in_op  input  16*N_NODES  per-node opcode, node i at bits [16i+15:16i].
REQ-009 SHALL provide port irq_ack  input  N_NODES  per-node acknowledge, one-cycle pulse.
REQ-010 SHALL provide port out_tick_irq  output  1  periodic tick to all nodes.
REQ-011 SHALL provide port out_mutex_irq  output  N_NODES  one-hot external-event IRQ.
REQ-012 SHALL provide port out_cmd_irq  output  N_NODES  per-node command-raised IRQ.

Function
REQ-013 SHALL count tick cycles 0..TICK_PERIOD-1 and wrap to 0; out_tick_irq SHALL be registered high exactly when the count is >= TICK_PERIOD-TICK_LEN.
REQ-014 SHALL synchronise ext_signal through 2 flops and detect rising edges on the synchronised value; an edge SHALL be visible to arbitration 3 cycles after the input transition.
REQ-015 SHALL hold a 4-bit priority per node, all reset to 0.
REQ-016 SHALL treat in_op of node i as SET_PRIO when (op & 16'h3FF0) == 16'h2F10, writing op[3:0] to node i's priority on the next edge; a node SHALL write only its own priority.
REQ-017 SHALL treat in_op of any node as RAISE when op[15:4] == 12'h3F1 and 1 <= op[3:0] <= N_NODES, targeting node op[3:0]-1; other values SHALL be ignored.
REQ-018 Mutex FSM SHALL have states IDLE, ACTIVE, GAP.
REQ-019 In IDLE, an edge or set pending flag SHALL select the winner (highest priority value, ties to lowest index) using priorities registered before any same-cycle SET_PRIO, and go to ACTIVE with out_mutex_irq one-hot at the winner from the next cycle.
REQ-020 ACTIVE SHALL last PULSE_LEN cycles or end early on irq_ack of the winning node, then go to GAP.
REQ-021 GAP SHALL last exactly 1 cycle with out_mutex_irq all zero, then return to IDLE.
REQ-022 An edge in ACTIVE or GAP SHALL set a one-deep pending flag (further edges lost); pending SHALL clear when consumed in IDLE.
REQ-023 Each node SHALL have an independent command channel with states IDLE, ACTIVE, GAP and pending flag, timed as REQ-019..REQ-022, with RAISE targeting it as the event.
REQ-024 Multiple RAISEs to the same node in one cycle SHALL count as one event.
REQ-025 irq_ack[i] SHALL end both node i's active command pulse and, if node i is the mutex winner, the mutex pulse, in the same cycle.
REQ-026 Pulse counters SHALL be $clog2(PULSE_LEN+1) bits and never wrap within a pulse; tick counter SHALL be $clog2(TICK_PERIOD) bits.
REQ-027 All outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-028 RST low SHALL asynchronously clear all counters, synchroniser flops, pending flags and priorities, force all FSMs to IDLE and all outputs to 0, including mid-pulse.
REQ-029 After RST rises, the tick count SHALL start from 0 and a ext_signal already high SHALL not generate an edge.

Verification (N_NODES=4, TICK_PERIOD=20, TICK_LEN=3, PULSE_LEN=5)
REQ-030 Free run 60 cycles after reset -> out_tick_irq high on counts 17,18,19 of each period, low otherwise.
REQ-031 SET_PRIO 16'h2F13 on node 2, 16'h2F15 on node 1, then ext_signal rise -> out_mutex_irq = 4'b0010 for 5 cycles, then 0.
REQ-032 All priorities equal, ext_signal pulsed twice during ACTIVE -> two pulses to node 0 separated by 1-cycle gap; third edge lost.
REQ-033 Node 3 issues 16'h3F12 and node 0 issues 16'h3F12 same cycle -> single 5-cycle pulse on out_cmd_irq[1]; 16'h3F15 -> no effect.
REQ-034 irq_ack[1] in 2nd cycle of command pulse to node 1 -> out_cmd_irq[1] low next cycle; RST low mid-pulse -> all outputs 0 immediately.

Source files
------------

// File: rtl/espic_n.sv
// ESPIC_N: periodic tick generator, external-event mutex IRQ arbiter and per-node
// command IRQ channels. All outputs come straight from flops.

module espic_n_chan #(
   parameter int PULSE_LEN = 1000,
   parameter int W         = 1
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         ev,
   input  logic         ack,
   input  logic [W-1:0] sel,
   output logic [W-1:0] irq
);
   localparam int CW = $clog2(PULSE_LEN + 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_GAP    = 2'd2
   } state_t;

   state_t        state_r, state_nxt_s;
   logic [CW-1:0] cnt_r, cnt_nxt_s;
   logic          pend_r, pend_nxt_s;
   logic [W-1:0]  irq_r, irq_nxt_s;

   // Next-state logic: events arriving while busy collapse into one pending flag
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      pend_nxt_s  = pend_r;
      irq_nxt_s   = irq_r;
      case (state_r)
         ST_IDLE: begin
            if (ev || pend_r) begin
               state_nxt_s = ST_ACTIVE;
               cnt_nxt_s   = CW'(1);
               pend_nxt_s  = 1'b0;
               irq_nxt_s   = sel;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_ACTIVE: begin
            pend_nxt_s = pend_r | ev;
            if (ack || (cnt_r == CW'(PULSE_LEN))) begin
               state_nxt_s = ST_GAP;
               cnt_nxt_s   = {CW{1'b0}};
               irq_nxt_s   = {W{1'b0}};
            end else begin
               cnt_nxt_s   = cnt_r + CW'(1);
            end
         end
         ST_GAP: begin
            pend_nxt_s  = pend_r | ev;
            state_nxt_s = ST_IDLE;
         end
         default: begin
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = {CW{1'b0}};
            pend_nxt_s  = 1'b0;
            irq_nxt_s   = {W{1'b0}};
         end
      endcase
   end

   // Channel state registers
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_r <= ST_IDLE;
         cnt_r   <= {CW{1'b0}};
         pend_r  <= 1'b0;
         irq_r   <= {W{1'b0}};
      end else begin
         state_r <= state_nxt_s;
         cnt_r   <= cnt_nxt_s;
         pend_r  <= pend_nxt_s;
         irq_r   <= irq_nxt_s;
      end
   end

   assign irq = irq_r;
endmodule

module espic_n #(
   parameter int N_NODES     = 2,
   parameter int TICK_PERIOD = 1000000000,
   parameter int TICK_LEN    = 100,
   parameter int PULSE_LEN   = 1000
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic                   ext_signal,
   input  logic [16*N_NODES-1:0]  in_op,
   input  logic [N_NODES-1:0]     irq_ack,
   output logic                   out_tick_irq,
   output logic [N_NODES-1:0]     out_mutex_irq,
   output logic [N_NODES-1:0]     out_cmd_irq
);
   localparam int TW = $clog2(TICK_PERIOD);

   logic [TW-1:0]      tick_cnt_r, tick_nxt_s;
   logic               tick_irq_r;
   logic               ext_meta_r, ext_sync_r, ext_prev_r;
   logic [1:0]         arm_r;
   logic               edge_s;
   logic [3:0]         prio_r [N_NODES];
   logic [N_NODES-1:0] set_s, raise_s, win_oh_s;
   logic [3:0]         best_s, win_s;
   logic               mutex_ack_s;

   // Tick counter wraps at TICK_PERIOD-1
   always_comb begin
      if (tick_cnt_r == TW'(TICK_PERIOD - 1)) begin
         tick_nxt_s = {TW{1'b0}};
      end else begin
         tick_nxt_s = tick_cnt_r + TW'(1);
      end
   end

   // Tick output is aligned to the count it describes
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         tick_cnt_r <= {TW{1'b0}};
         tick_irq_r <= 1'b0;
      end else begin
         tick_cnt_r <= tick_nxt_s;
         tick_irq_r <= (tick_nxt_s >= TW'(TICK_PERIOD - TICK_LEN));
      end
   end

   // Two-flop synchroniser plus edge history; arm_r blocks fake edges from reset values
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         ext_meta_r <= 1'b0;
         ext_sync_r <= 1'b0;
         ext_prev_r <= 1'b0;
         arm_r      <= 2'd0;
      end else begin
         ext_meta_r <= ext_signal;
         ext_sync_r <= ext_meta_r;
         ext_prev_r <= ext_sync_r;
         if (arm_r != 2'd3) begin
            arm_r <= arm_r + 2'd1;
         end
      end
   end

   assign edge_s = ext_sync_r & ~ext_prev_r & (arm_r == 2'd3);

   // Opcode decode; several RAISEs to one node in a cycle merge into one event
   always_comb begin
      set_s   = {N_NODES{1'b0}};
      raise_s = {N_NODES{1'b0}};
      for (int i = 0; i < N_NODES; i++) begin
         set_s[i] = ((in_op[16*i +: 16] & 16'h3FF0) == 16'h2F10);
      end
      for (int j = 0; j < N_NODES; j++) begin
         for (int i = 0; i < N_NODES; i++) begin
            raise_s[j] = raise_s[j] |
                         ((in_op[16*i+4 +: 12] == 12'h3F1) && (in_op[16*i +: 4] == 4'(j + 1)));
         end
      end
   end

   // Each node writes only its own priority
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         for (int i = 0; i < N_NODES; i++) begin
            prio_r[i] <= 4'd0;
         end
      end else begin
         for (int i = 0; i < N_NODES; i++) begin
            if (set_s[i]) begin
               prio_r[i] <= in_op[16*i +: 4];
            end
         end
      end
   end

   // Winner: highest priority, strict compare keeps the lowest index on ties
   always_comb begin
      best_s   = prio_r[0];
      win_s    = 4'd0;
      win_oh_s = {N_NODES{1'b0}};
      for (int i = 1; i < N_NODES; i++) begin
         if (prio_r[i] > best_s) begin
            best_s = prio_r[i];
            win_s  = 4'(i);
         end else begin
            best_s = best_s;
            win_s  = win_s;
         end
      end
      for (int i = 0; i < N_NODES; i++) begin
         win_oh_s[i] = (win_s == 4'(i));
      end
   end

   assign mutex_ack_s = |(irq_ack & out_mutex_irq);

   espic_n_chan #(.PULSE_LEN(PULSE_LEN), .W(N_NODES)) u_mutex (
      .CLK (CLK),
      .RST (RST),
      .ev  (edge_s),
      .ack (mutex_ack_s),
      .sel (win_oh_s),
      .irq (out_mutex_irq)
   );

   for (genvar g = 0; g < N_NODES; g++) begin : g_cmd
      espic_n_chan #(.PULSE_LEN(PULSE_LEN), .W(1)) u_cmd (
         .CLK (CLK),
         .RST (RST),
         .ev  (raise_s[g]),
         .ack (irq_ack[g]),
         .sel (1'b1),
         .irq (out_cmd_irq[g +: 1])
      );
   end

   assign out_tick_irq = tick_irq_r;
endmodule

// File: tb/tb_espic_n.sv
// Randomised and directed bench for espic_n against a cycle-level behavioural model.

module tb_espic_n;
   localparam int N  = 4;
   localparam int P  = 20;
   localparam int L  = 3;
   localparam int PL = 5;

   logic           CLK = 1'b0;
   logic           RST = 1'b1;
   logic           ext_signal = 1'b0;
   logic [16*N-1:0] in_op = '0;
   logic [N-1:0]   irq_ack = '0;
   logic           out_tick_irq;
   logic [N-1:0]   out_mutex_irq;
   logic [N-1:0]   out_cmd_irq;

   int n_tests = 0;
   int n_fail  = 0;

   // model state
   int   k;
   bit   ext_q[$];
   int   prio[N];
   int   m_remain, m_lock, m_win;
   bit   m_pend;
   int   c_remain[N], c_lock[N];
   bit   c_pend[N];
   logic exp_tick;
   logic [N-1:0] exp_mutex, exp_cmd;

   espic_n #(.N_NODES(N), .TICK_PERIOD(P), .TICK_LEN(L), .PULSE_LEN(PL)) dut (
      .CLK           (CLK),
      .RST           (RST),
      .ext_signal    (ext_signal),
      .in_op         (in_op),
      .irq_ack       (irq_ack),
      .out_tick_irq  (out_tick_irq),
      .out_mutex_irq (out_mutex_irq),
      .out_cmd_irq   (out_cmd_irq)
   );

   always #5 CLK = ~CLK;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, k, got, exp);
      end
   endtask

   // One channel: remain = high cycles still to come, lock = edges still refused after a pulse
   task automatic chan_step(input bit ev, input bit ack, inout int remain, inout int lock,
                            inout bit pend, output bit started);
      started = 1'b0;
      if (remain == 0 && lock == 0) begin
         if (ev || pend) begin
            remain  = PL;
            pend    = 1'b0;
            started = 1'b1;
         end
      end else begin
         if (ev) pend = 1'b1;
         if (remain > 0) begin
            if (ack || remain == 1) begin
               remain = 0;
               lock   = 1;
            end else begin
               remain--;
            end
         end else begin
            lock--;
         end
      end
   endtask

   task automatic model_reset();
      k = 0;
      ext_q.delete();
      m_remain = 0; m_lock = 0; m_win = 0; m_pend = 1'b0;
      for (int i = 0; i < N; i++) begin
         prio[i] = 0; c_remain[i] = 0; c_lock[i] = 0; c_pend[i] = 1'b0;
      end
   endtask

   task automatic model_step(input logic [16*N-1:0] ops, input bit ext, input logic [N-1:0] ack);
      bit mev, cev, st;
      int best, w;
      logic [15:0] op;
      k++;
      ext_q.push_back(ext);
      // a rise between the values sampled at edges k-3 and k-2 is arbitrated at edge k
      mev = (k >= 4) && ext_q[k-3] && !ext_q[k-4];
      best = -1; w = 0;
      for (int i = 0; i < N; i++) begin
         if (prio[i] > best) begin best = prio[i]; w = i; end
      end
      chan_step(mev, (m_remain > 0) && ack[m_win], m_remain, m_lock, m_pend, st);
      if (st) m_win = w;
      for (int j = 0; j < N; j++) begin
         cev = 1'b0;
         for (int i = 0; i < N; i++) begin
            op = ops[16*i +: 16];
            if (op == 16'h3F11 + 16'(j)) cev = 1'b1;
         end
         chan_step(cev, ack[j], c_remain[j], c_lock[j], c_pend[j], st);
      end
      for (int i = 0; i < N; i++) begin
         op = ops[16*i +: 16];
         if ((op & 16'h3FF0) == 16'h2F10) prio[i] = int'(op[3:0]);
      end
      exp_tick  = ((k % P) >= (P - L));
      exp_mutex = '0;
      if (m_remain > 0) exp_mutex[m_win] = 1'b1;
      for (int j = 0; j < N; j++) exp_cmd[j] = (c_remain[j] > 0);
   endtask

   task automatic cycle(input logic [16*N-1:0] ops, input bit ext, input logic [N-1:0] ack);
      in_op = ops; ext_signal = ext; irq_ack = ack;
      @(posedge CLK);
      model_step(ops, ext, ack);
      #1;
      check_eq("tick",  32'(out_tick_irq),  32'(exp_tick));
      check_eq("mutex", 32'(out_mutex_irq), 32'(exp_mutex));
      check_eq("cmd",   32'(out_cmd_irq),   32'(exp_cmd));
   endtask

   task automatic do_reset(input bit ext);
      in_op = '0; irq_ack = '0; ext_signal = ext;
      RST = 1'b0;
      #1;
      check_eq("rst_tick",  32'(out_tick_irq),  32'd0);
      check_eq("rst_mutex", 32'(out_mutex_irq), 32'd0);
      check_eq("rst_cmd",   32'(out_cmd_irq),   32'd0);
      @(posedge CLK);
      @(posedge CLK);
      #1;
      RST = 1'b1;
      model_reset();
   endtask

   function automatic logic [16*N-1:0] op_at(input int node, input logic [15:0] op);
      logic [16*N-1:0] v;
      v = '0;
      v[16*node +: 16] = op;
      return v;
   endfunction

   function automatic logic [15:0] rand_op();
      case ($urandom_range(0, 9))
         0:       return 16'h2F10 | 16'($urandom_range(0, 15));
         1:       return 16'hEF10 | 16'($urandom_range(0, 15));
         2, 3:    return 16'h3F10 + 16'($urandom_range(0, 6));
         4:       return 16'($urandom);
         default: return 16'h0000;
      endcase
   endfunction

   initial begin
      int hits;
      int rises;
      logic prev;
      logic [16*N-1:0] ops;
      logic [N-1:0] ack;
      bit ext_r;

      #2;
      // ext_signal held high across reset must not produce an edge; tick free run
      do_reset(1'b1);
      repeat (60) cycle('0, 1'b1, '0);

      // node 1 outranks node 2 after SET_PRIO
      do_reset(1'b0);
      repeat (3) cycle('0, 1'b0, '0);
      cycle(op_at(2, 16'h2F13), 1'b0, '0);
      cycle(op_at(1, 16'h2F15), 1'b0, '0);
      hits = 0;
      repeat (14) begin
         cycle('0, 1'b1, '0);
         if (out_mutex_irq == 4'b0010) hits++;
      end
      check_eq("prio_win_len", 32'(hits), 32'd5);

      // three quick edges: one pulse, one pending, one lost
      do_reset(1'b0);
      repeat (4) cycle('0, 1'b0, '0);
      rises = 0; prev = 1'b0;
      for (int i = 0; i < 24; i++) begin
         cycle('0, (i < 6) ? bit'(i % 2 == 0) : 1'b0, '0);
         if (out_mutex_irq[0] && !prev) rises++;
         prev = out_mutex_irq[0];
      end
      check_eq("pending_pulses", 32'(rises), 32'd2);

      // duplicate RAISE merges into one pulse; out-of-range target ignored
      do_reset(1'b0);
      repeat (4) cycle('0, 1'b0, '0);
      hits = 0;
      cycle(op_at(3, 16'h3F12) | op_at(0, 16'h3F12), 1'b0, '0);
      if (out_cmd_irq == 4'b0010) hits++;
      repeat (9) begin
         cycle('0, 1'b0, '0);
         if (out_cmd_irq == 4'b0010) hits++;
      end
      check_eq("raise_len", 32'(hits), 32'd5);
      hits = 0;
      cycle(op_at(0, 16'h3F15), 1'b0, '0);
      repeat (8) begin
         cycle('0, 1'b0, '0);
         if (out_cmd_irq != 4'b0000) hits++;
      end
      check_eq("raise_oob", 32'(hits), 32'd0);

      // ack in the 2nd pulse cycle ends the pulse on the next cycle
      cycle(op_at(2, 16'h3F12), 1'b0, '0);
      cycle('0, 1'b0, '0);
      cycle('0, 1'b0, 4'b0010);
      check_eq("ack_end", 32'(out_cmd_irq[1]), 32'd0);
      repeat (4) cycle('0, 1'b0, '0);

      // reset in the middle of both a command and a mutex pulse
      cycle(op_at(0, 16'h3F13), 1'b1, '0);
      repeat (3) cycle('0, 1'b1, '0);
      check_eq("pre_rst_busy", 32'(out_cmd_irq[2] & out_mutex_irq[0]), 32'd1);
      do_reset(1'b1);

      // randomised traffic with one reset part way through
      ext_r = 1'b1;
      for (int n = 0; n < 1500; n++) begin
         if (n == 800) do_reset(ext_r);
         for (int i = 0; i < N; i++) ops[16*i +: 16] = rand_op();
         for (int i = 0; i < N; i++) ack[i] = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 5) == 0) ext_r = ~ext_r;
         cycle(ops, ext_r, ack);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
